// File: rtl/adder_tree_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_tree_ctrl: layer sequencer and credit tracker for the conv adder tree|
// | Optional: ADDER_CTRL_PERF_EN adds the perf_stall stall-cycle counter.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adder_tree_ctrl #(
  parameter int RW      = 4,
  parameter int ROW_W   = 8,
  parameter int MAX_OUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cfg_wsize,
  input  logic             cfg_stride,
  input  logic [RW-1:0]    cfg_rounds,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tree_valid,
  output logic             tree_stride,
  output logic [RW-1:0]    tree_round,
  output logic [1:0]       tree_wsize,
  output logic [1:0]       tree_rlpad,
  input  logic             res_valid,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
`ifdef ADDER_CTRL_PERF_EN
  ,
  output logic [15:0]      perf_stall
`endif
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CREDIT_FULL = CW'(MAX_OUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         wsize_q, wsize_d;
  logic               stride_q, stride_d;
  logic [RW-1:0]      rounds_q, rounds_d;
  logic [ROW_W-1:0]   rows_q, rows_d;
  logic [RW-1:0]      round_cnt_q, round_cnt_d;
  logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
  logic [CW-1:0]      credits_q, credits_d;
  logic               tree_valid_q, tree_valid_d;
  logic               tree_stride_q, tree_stride_d;
  logic [RW-1:0]      tree_round_q, tree_round_d;
  logic [1:0]         tree_wsize_q, tree_wsize_d;
  logic [1:0]         tree_rlpad_q, tree_rlpad_d;
  logic               cfg_err_q, cfg_err_d;

  logic cfg_ok;
  logic fire;
  logic last_round;
  logic last_row;

  always_comb begin
    cfg_ok     = (cfg_wsize != 2'd3) && (cfg_rounds != '0) && (cfg_rows != '0);
    in_ready   = (state_q == S_RUN) && (credits_q != '0);
    fire       = in_valid && in_ready;
    last_round = (round_cnt_q == (rounds_q - RW'(1)));
    last_row   = (row_cnt_q == (rows_q - ROW_W'(1)));
  end

  // A return arriving with the pool already full has no beat to account for.
  always_comb begin
    credits_d = credits_q;
    if (fire && !res_valid) begin
      credits_d = credits_q - CW'(1);
    end else if (!fire && res_valid && (credits_q != CREDIT_FULL)) begin
      credits_d = credits_q + CW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    wsize_d       = wsize_q;
    stride_d      = stride_q;
    rounds_d      = rounds_q;
    rows_d        = rows_q;
    round_cnt_d   = round_cnt_q;
    row_cnt_d     = row_cnt_q;
    tree_valid_d  = fire;
    tree_stride_d = tree_stride_q;
    tree_round_d  = tree_round_q;
    tree_wsize_d  = tree_wsize_q;
    tree_rlpad_d  = tree_rlpad_q;
    cfg_err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            wsize_d  = cfg_wsize;
            stride_d = cfg_stride;
            rounds_d = cfg_rounds;
            rows_d   = cfg_rows;
            state_d  = S_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        round_cnt_d = '0;
        row_cnt_d   = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (fire) begin
          tree_stride_d = stride_q;
          tree_wsize_d  = wsize_q;
          tree_round_d  = round_cnt_q;
          tree_rlpad_d  = {(round_cnt_q == '0), last_round};
          if (last_round) begin
            round_cnt_d = '0;
            row_cnt_d   = row_cnt_q + ROW_W'(1);
            if (last_row) begin
              state_d = S_DRAIN;
            end
          end else begin
            round_cnt_d = round_cnt_q + RW'(1);
          end
        end
      end
      // Look at the updated pool so done follows the last result by one cycle.
      S_DRAIN: begin
        if (credits_d == CREDIT_FULL) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wsize_q       <= '0;
      stride_q      <= 1'b0;
      rounds_q      <= '0;
      rows_q        <= '0;
      round_cnt_q   <= '0;
      row_cnt_q     <= '0;
      credits_q     <= CREDIT_FULL;
      tree_valid_q  <= 1'b0;
      tree_stride_q <= 1'b0;
      tree_round_q  <= '0;
      tree_wsize_q  <= '0;
      tree_rlpad_q  <= '0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wsize_q       <= wsize_d;
      stride_q      <= stride_d;
      rounds_q      <= rounds_d;
      rows_q        <= rows_d;
      round_cnt_q   <= round_cnt_d;
      row_cnt_q     <= row_cnt_d;
      credits_q     <= credits_d;
      tree_valid_q  <= tree_valid_d;
      tree_stride_q <= tree_stride_d;
      tree_round_q  <= tree_round_d;
      tree_wsize_q  <= tree_wsize_d;
      tree_rlpad_q  <= tree_rlpad_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  always_comb begin
    tree_valid  = tree_valid_q;
    tree_stride = tree_stride_q;
    tree_round  = tree_round_q;
    tree_wsize  = tree_wsize_q;
    tree_rlpad  = tree_rlpad_q;
    cfg_err     = cfg_err_q;
    busy        = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
    done        = (state_q == S_DONE);
  end

`ifdef ADDER_CTRL_PERF_EN
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    if (state_q == S_LOAD) begin
      perf_stall_d = '0;
    end else if ((state_q == S_RUN) && in_valid && !in_ready && (perf_stall_q != 16'hFFFF)) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
    end
  end

  always_comb begin
    perf_stall = perf_stall_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_ctrl.sv
`default_nettype none
// Bench for adder_tree_ctrl: table of layer configs, hand-written credit and
// reset sequences, and random layers against a transaction-level model.
module tb_adder_tree_ctrl;

  localparam int RW      = 4;
  localparam int ROW_W   = 8;
  localparam int MAX_OUT = 2;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       cfg_wsize = '0;
  logic             cfg_stride = 1'b0;
  logic [RW-1:0]    cfg_rounds = '0;
  logic [ROW_W-1:0] cfg_rows = '0;
  logic             in_valid = 1'b0;
  logic             res_valid = 1'b0;
  logic             in_ready;
  logic             tree_valid;
  logic             tree_stride;
  logic [RW-1:0]    tree_round;
  logic [1:0]       tree_wsize;
  logic [1:0]       tree_rlpad;
  logic             busy;
  logic             done;
  logic             cfg_err;
`ifdef ADDER_CTRL_PERF_EN
  logic [15:0]      perf_stall;
`endif

  adder_tree_ctrl #(.RW(RW), .ROW_W(ROW_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_wsize(cfg_wsize), .cfg_stride(cfg_stride),
    .cfg_rounds(cfg_rounds), .cfg_rows(cfg_rows),
    .in_valid(in_valid), .in_ready(in_ready),
    .tree_valid(tree_valid), .tree_stride(tree_stride),
    .tree_round(tree_round), .tree_wsize(tree_wsize), .tree_rlpad(tree_rlpad),
    .res_valid(res_valid), .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef ADDER_CTRL_PERF_EN
    , .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: layer phase, beats outstanding in the tree, expected beat list
  int         ph;
  int         outstanding;
  bit         tv_pend, err_pend;
  int         exp_round;
  logic [1:0] exp_rlpad, exp_wsize;
  logic       exp_stride;
  logic [1:0] m_wsize;
  logic       m_stride;
  int         issued, total_beats;
  int         round_list[$];
  logic [1:0] pad_list[$];
  int         stall_m;
  int         cyc;
  int         due_q[$];
  int         last_due;
  int         dly_min, dly_max;
  bit         hold_res, force_res;

  int         seen_rounds[$];
  logic [1:0] seen_pads[$];
  int         dones_seen, errs_seen;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; outstanding = 0; tv_pend = 0; err_pend = 0;
    exp_round = 0; exp_rlpad = '0; exp_wsize = '0; exp_stride = 1'b0;
    stall_m = 0; issued = 0; total_beats = 0;
    due_q.delete(); last_due = -1; hold_res = 0; force_res = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready",    in_ready,    (ph == P_RUN) && (outstanding < MAX_OUT));
    chk("busy",        busy,        (ph == P_LOAD) || (ph == P_RUN) || (ph == P_DRAIN));
    chk("done",        done,        ph == P_DONE);
    chk("cfg_err",     cfg_err,     err_pend);
    chk("tree_valid",  tree_valid,  tv_pend);
    chk("tree_round",  tree_round,  exp_round);
    chk("tree_rlpad",  tree_rlpad,  exp_rlpad);
    chk("tree_wsize",  tree_wsize,  exp_wsize);
    chk("tree_stride", tree_stride, exp_stride);
`ifdef ADDER_CTRL_PERF_EN
    chk("perf_stall",  perf_stall,  stall_m);
`endif
    if (tree_valid === 1'b1) begin
      seen_rounds.push_back(int'(tree_round));
      seen_pads.push_back(tree_rlpad);
    end
    if (done === 1'b1) dones_seen++;
    if (cfg_err === 1'b1) errs_seen++;
  endtask

  task automatic model_step();
    bit rdy, f;
    int due, rd, rw;
    rdy = (ph == P_RUN) && (outstanding < MAX_OUT);
    f = in_valid && rdy;
    if (ph == P_LOAD) stall_m = 0;
    else if (ph == P_RUN && in_valid && !rdy && stall_m < 65535) stall_m++;
    err_pend = 0;
    tv_pend = f;
    if (f) begin
      exp_round = round_list[issued];
      exp_rlpad = pad_list[issued];
      exp_wsize = m_wsize;
      exp_stride = m_stride;
      issued++;
      due = cyc + 1 + int'($urandom_range(dly_max, dly_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      due_q.push_back(due);
    end
    if (f && !res_valid) outstanding++;
    else if (!f && res_valid && outstanding > 0) outstanding--;
    case (ph)
      P_IDLE: if (start) begin
        if (cfg_wsize != 2'd3 && cfg_rounds != 0 && cfg_rows != 0) begin
          m_wsize = cfg_wsize; m_stride = cfg_stride;
          rd = int'(cfg_rounds); rw = int'(cfg_rows);
          round_list.delete(); pad_list.delete();
          for (int r = 0; r < rw; r++)
            for (int k = 0; k < rd; k++) begin
              round_list.push_back(k);
              pad_list.push_back({k == 0, k == rd - 1});
            end
          total_beats = rd * rw;
          issued = 0;
          ph = P_LOAD;
        end else begin
          err_pend = 1;
        end
      end
      P_LOAD:  ph = P_RUN;
      P_RUN:   if (f && issued == total_beats) ph = P_DRAIN;
      P_DRAIN: if (outstanding == 0) ph = P_DONE;
      P_DONE:  ph = P_IDLE;
      default: ph = P_IDLE;
    endcase
  endtask

  // One clock: check current outputs, choose res_valid, advance the model.
  task automatic tick();
    int d;
    check_outputs();
    res_valid = 1'b0;
    if (force_res) begin
      res_valid = 1'b1; force_res = 0;
      if (due_q.size() > 0) d = due_q.pop_front();
    end else if (!hold_res && due_q.size() > 0 && due_q[0] <= cyc) begin
      res_valid = 1'b1;
      d = due_q.pop_front();
    end
    model_step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; res_valid = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cyc += 2;
  endtask

  task automatic clear_seen();
    seen_rounds.delete(); seen_pads.delete(); dones_seen = 0; errs_seen = 0;
  endtask

  task automatic run_layer(input logic [1:0] w, input logic s, input int rd, input int rw,
                           input int iv_pct, input int dmin, input int dmax);
    int n;
    dly_min = dmin; dly_max = dmax;
    cfg_wsize = w; cfg_stride = s; cfg_rounds = RW'(rd); cfg_rows = ROW_W'(rw);
    start = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0;
    n = 0;
    while (ph != P_IDLE && n < 2000) begin
      in_valid = ($urandom_range(99, 0) < iv_pct);
      tick();
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL layer_timeout: got %0d cycles expected fewer than 2000", n);
    end
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
  endtask

  typedef struct {
    logic [1:0] wsize;
    logic       stride;
    int         rounds;
    int         rows;
    int         exp_err;
    int         exp_beats;
    logic [1:0] first_pad;
    logic [1:0] last_pad;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit legal;
    vecs[0] = '{2'd1, 1'b0, 3,  2, 0, 6,  2'b10, 2'b01};
    vecs[1] = '{2'd2, 1'b0, 1,  1, 0, 1,  2'b11, 2'b11};
    vecs[2] = '{2'd0, 1'b1, 2,  3, 0, 6,  2'b10, 2'b01};
    vecs[3] = '{2'd3, 1'b0, 2,  2, 1, 0,  2'b00, 2'b00};
    vecs[4] = '{2'd1, 1'b1, 4,  1, 0, 4,  2'b10, 2'b01};
    vecs[5] = '{2'd0, 1'b0, 0,  2, 1, 0,  2'b00, 2'b00};
    vecs[6] = '{2'd2, 1'b1, 2,  0, 1, 0,  2'b00, 2'b00};
    vecs[7] = '{2'd0, 1'b0, 15, 2, 0, 30, 2'b10, 2'b01};

    cyc = 0;
    model_reset();
    dly_min = 2; dly_max = 2;
    #1;
    do_reset();
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      clear_seen();
      run_layer(vecs[i].wsize, vecs[i].stride, vecs[i].rounds, vecs[i].rows, 100, 2, 2);
      chk("vec_beats", seen_pads.size(), vecs[i].exp_beats);
      chk("vec_cfg_err", errs_seen, vecs[i].exp_err);
      chk("vec_done", dones_seen, (vecs[i].exp_err == 0) ? 1 : 0);
      if (seen_pads.size() > 0) begin
        chk("vec_first_pad", seen_pads[0], vecs[i].first_pad);
        chk("vec_last_pad", seen_pads[seen_pads.size()-1], vecs[i].last_pad);
      end
    end

    // Credit exhaustion with results withheld, then a single return
    clear_seen();
    hold_res = 1; dly_min = 2; dly_max = 2;
    cfg_wsize = 2'd1; cfg_stride = 1'b0; cfg_rounds = RW'(3); cfg_rows = ROW_W'(2);
    start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("hold_fires", seen_rounds.size(), 2);
    chk("hold_ready", in_ready, 0);
`ifdef ADDER_CTRL_PERF_EN
    chk("perf_four_stalls", perf_stall, 4);
`endif
    force_res = 1;
    tick();
    chk("return_ready", in_ready, 1);
    tick();
    tick();
    chk("return_fires", seen_rounds.size(), 3);
    chk("return_ready_low", in_ready, 0);
    hold_res = 0;
    n = 0;
    while (ph != P_IDLE && n < 200) begin tick(); n++; end
    in_valid = 1'b0;
    tick();
    chk("hold_total_beats", seen_rounds.size(), 6);
    chk("hold_done", dones_seen, 1);

    // Stray return while idle must not inflate the pool
    force_res = 1;
    tick();
    chk("idle_stray_ready", in_ready, 0);

    // Reset in the middle of a layer, then a clean full layer
    clear_seen();
    cfg_wsize = 2'd1; cfg_stride = 1'b0; cfg_rounds = RW'(3); cfg_rows = ROW_W'(2);
    start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (seen_rounds.size() < 3 && n < 100) begin tick(); n++; end
    chk("pre_reset_beats", seen_rounds.size(), 3);
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_tree_valid", tree_valid, 0);
    tick();
    clear_seen();
    run_layer(2'd1, 1'b0, 3, 2, 100, 2, 2);
    chk("post_reset_beats", seen_rounds.size(), 6);
    for (int i = 0; i < seen_rounds.size(); i++)
      chk("post_reset_round", seen_rounds[i], i % 3);

    // Random layers
    for (int l = 0; l < 25; l++) begin
      logic [1:0] w;
      int rd, rw;
      w = 2'($urandom_range(3, 0));
      rd = int'($urandom_range(4, 0));
      rw = int'($urandom_range(3, 0));
      legal = (w != 2'd3) && (rd != 0) && (rw != 0);
      clear_seen();
      run_layer(w, 1'($urandom_range(1, 0)), rd, rw,
                int'($urandom_range(100, 30)), 0, int'($urandom_range(4, 0)));
      chk("rand_beats", seen_rounds.size(), legal ? rd * rw : 0);
      chk("rand_done", dones_seen, legal ? 1 : 0);
      chk("rand_err", errs_seen, legal ? 0 : 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
